// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the fetch-stage
// instruction port and the MEM-stage data port. Data requests win over
// instruction requests. Each access runs IDLE -> DACC/IACC -> RESP -> IDLE,
// and the hit strobe for the served port is raised in RESP.
// Optional build macro: MEM_ARB_WDOG_EN adds a watchdog that ends an access
// that has waited WDOG_CYCLES for ram_rdy. It then raises a sticky mem_err.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WDOG_CYCLES = 255
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dhit,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_rdy,
   output logic              mem_err
);

   typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

   state_t              state_reg, state_next;
   logic                op_wr_reg;      // latched access is a write
   logic                served_d_reg;   // latched access belongs to the data port
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   store_reg;
   logic [DATA_W-1:0]   iload_reg, dload_reg;
   logic                access;         // RAM access in flight
   logic                wdog_fire;      // watchdog ends the access this cycle
   logic                done;           // access completes at the coming edge
   logic                data_req;

   assign access   = (state_reg == DACC) || (state_reg == IACC);
   assign data_req = dREN | dWEN;
   assign done     = access && (ram_rdy || wdog_fire);

`ifdef MEM_ARB_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_reg;
   logic            mem_err_reg;

   // The timeout fires on the wait cycle that brings the counter to WDOG_CYCLES.
   assign wdog_fire = access && !ram_rdy && (wd_cnt_reg == WD_W'(WDOG_CYCLES - 1));
   assign mem_err   = mem_err_reg;

   // Count wait cycles of the current access. The counter is held at zero outside
   // an access, so it starts cleared on entry. mem_err is sticky until reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wd_cnt_reg  <= '0;
         mem_err_reg <= 1'b0;
      end else begin
         if (!access)
            wd_cnt_reg <= '0;
         else if (!ram_rdy)
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
         if (wdog_fire)
            mem_err_reg <= 1'b1;
      end
   end
`else
   logic unused_wdog;

   assign unused_wdog = |WDOG_CYCLES;
   assign wdog_fire   = 1'b0;
   assign mem_err     = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic: data wins in IDLE, accesses run to completion, RESP lasts one cycle
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (data_req)
               state_next = DACC;
            else if (iREN)
               state_next = IACC;
         end
         DACC, IACC: begin
            if (done)
               state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latch the winning request in IDLE. Request changes during the access are ignored.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         op_wr_reg    <= 1'b0;
         served_d_reg <= 1'b0;
         addr_reg     <= '0;
         store_reg    <= '0;
      end else if (state_reg == IDLE) begin
         if (data_req) begin
            op_wr_reg    <= dWEN;
            served_d_reg <= 1'b1;
            addr_reg     <= daddr;
            store_reg    <= dstore;
         end else if (iREN) begin
            op_wr_reg    <= 1'b0;
            served_d_reg <= 1'b0;
            addr_reg     <= iaddr;
         end
      end
   end

   // Capture read data when the access ends. A watchdog timeout returns zero.
   // Writes leave the load registers untouched.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         iload_reg <= '0;
         dload_reg <= '0;
      end else if (done && !op_wr_reg) begin
         if (served_d_reg)
            dload_reg <= ram_rdy ? ramload : '0;
         else
            iload_reg <= ram_rdy ? ramload : '0;
      end
   end

   // RAM enables follow the state register, so reset drops them asynchronously.
   assign ramREN   = access && !op_wr_reg;
   assign ramWEN   = access && op_wr_reg;
   assign ramaddr  = access ? addr_reg : '0;
   assign ramstore = ramWEN ? store_reg : '0;

   assign dhit  = (state_reg == RESP) && served_d_reg;
   assign ihit  = (state_reg == RESP) && !served_d_reg;
   assign iload = iload_reg;
   assign dload = dload_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a simple
// RAM responder and a reference memory. The reference applies accesses in
// arbitration order (data before instruction) to a plain array.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int WD = 8;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          iREN, dREN, dWEN, ram_rdy;
   logic [AW-1:0] iaddr, daddr, ramaddr;
   logic [DW-1:0] iload, dload, dstore, ramstore, ramload;
   logic          ihit, dhit, ramREN, ramWEN, mem_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ihit_cnt = 0;
   int dhit_cnt = 0;
   int rdy_delay = 0;     // wait cycles before ram_rdy; negative means never
   bit noise_en  = 1'b0;  // random ram_rdy pulses while no access is in flight

   logic [DW-1:0] mem     [256];   // RAM contents
   logic [DW-1:0] ref_mem [256];   // expected RAM contents

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ram_op_t;
   ram_op_t ops[$];

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      if (o !== e) begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(WD)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_rdy(ram_rdy), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   // Hit counting and port-exclusivity checks on the falling edge
   always @(negedge CLK) begin
      if (nRST) begin
         if (ihit) ihit_cnt++;
         if (dhit) dhit_cnt++;
         chk("both_hits", (ihit && dhit), 1'b0);
         chk("both_enables", (ramREN && ramWEN), 1'b0);
      end
   end

   // RAM responder: raises ram_rdy after rdy_delay wait cycles and logs each access
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      ram_rdy  = 1'b0;
      ramload  = '0;
      forever begin
         @(posedge CLK);
         #1;
         ramload = $urandom;
         if ((ramREN || ramWEN) && rdy_delay >= 0 && wait_cnt == rdy_delay) begin
            ram_rdy = 1'b1;
            if (ramWEN)
               mem[ramaddr[9:2]] = ramstore;
            else
               ramload = mem[ramaddr[9:2]];
            ops.push_back('{we: ramWEN, addr: ramaddr, data: (ramWEN ? ramstore : ramload)});
            wait_cnt = 0;
         end else begin
            ram_rdy = noise_en && !(ramREN || ramWEN) ? 1'($urandom_range(0, 1)) : 1'b0;
            wait_cnt = (ramREN || ramWEN) ? wait_cnt + 1 : 0;
         end
      end
   end

   task automatic wait_hit(input bit want_d, input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge CLK);
         if (want_d ? dhit : ihit) begin
            ok = 1'b1;
            at = cyc;
            return;
         end
      end
   endtask

   task automatic check_op(input string tag, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] v);
      ram_op_t op;
      chk({tag, "_present"}, (ops.size() > 0), 1'b1);
      if (ops.size() > 0) begin
         op = ops.pop_front();
         chk({tag, "_we"}, op.we, we);
         chk({tag, "_addr"}, op.addr, a);
         if (we) chk({tag, "_wdata"}, op.data, v);
      end
   endtask

   // One transaction on either or both ports. Requests are dropped at the edge after the hit.
   task automatic run_pair(input int id, input bit use_d, input bit d_wr,
                           input logic [AW-1:0] da, input logic [DW-1:0] dv,
                           input bit use_i, input logic [AW-1:0] ia, input int dly);
      logic [DW-1:0] exp_d, exp_i;
      int  start, d_at, i_at, i0, d0;
      bit  got_d, got_i;
      exp_d = ref_mem[da[9:2]];
      if (use_d && d_wr) ref_mem[da[9:2]] = dv;
      exp_i = ref_mem[ia[9:2]];
      rdy_delay = dly;
      i0 = ihit_cnt;
      d0 = dhit_cnt;
      @(posedge CLK);
      #1;
      start = cyc;
      dREN  = use_d && (!d_wr || 1'($urandom_range(0, 1)));
      dWEN  = use_d && d_wr;
      daddr = da;
      dstore = dv;
      iREN  = use_i;
      iaddr = ia;
      got_d = !use_d;
      got_i = !use_i;
      d_at = -1;
      i_at = -1;
      for (int c = 0; c < 200 && !(got_d && got_i); c++) begin
         @(negedge CLK);
         if (dhit && use_d && !got_d) begin
            got_d = 1'b1;
            d_at  = cyc - start;
            if (!d_wr) chk("dload", dload, exp_d);
         end
         if (ihit && use_i && !got_i) begin
            got_i = 1'b1;
            i_at  = cyc - start;
            chk("iload", iload, exp_i);
         end
         @(posedge CLK);
         #1;
         if (got_d) begin dREN = 1'b0; dWEN = 1'b0; daddr = $urandom; end
         if (got_i) begin iREN = 1'b0; iaddr = $urandom; end
      end
      chk("d_done", got_d, 1'b1);
      chk("i_done", got_i, 1'b1);
      if (use_d) begin
         chk("d_latency", d_at, dly + 2);
         check_op("d_op", d_wr, da, dv);
      end
      if (use_i) begin
         chk("i_latency", i_at, use_d ? 2 * dly + 5 : dly + 2);
         check_op("i_op", 1'b0, ia, '0);
      end
      repeat (2) @(negedge CLK);
      chk("ihit_count", ihit_cnt - i0, int'(use_i));
      chk("dhit_count", dhit_cnt - d0, int'(use_d));
      chk("no_mem_err", mem_err, 1'b0);
      $display("txn %0d: d=%0b wr=%0b daddr=%0h i=%0b iaddr=%0h dly=%0d d_at=%0d i_at=%0d",
               id, use_d, d_wr, da, use_i, ia, dly, d_at, i_at);
   endtask

   initial begin
      int  at0, at1, i0, start;
      bit  ok;
      logic [DW-1:0] e0, e1;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[16]     = 32'hDEADBEEF;
      ref_mem[16] = 32'hDEADBEEF;
      nRST = 1'b0;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;

      // Reset values
      repeat (3) @(negedge CLK);
      chk("rst_ihit", ihit, 1'b0);
      chk("rst_dhit", dhit, 1'b0);
      chk("rst_iload", iload, 32'h0);
      chk("rst_dload", dload, 32'h0);
      chk("rst_ramREN", ramREN, 1'b0);
      chk("rst_ramWEN", ramWEN, 1'b0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
      chk("rst_mem_err", mem_err, 1'b0);
      nRST = 1'b1;

      // Reset during an instruction access
      rdy_delay = -1;
      @(posedge CLK); #1;
      iREN = 1'b1; iaddr = 32'h100;
      repeat (2) @(negedge CLK);
      chk("midrst_ramREN_before", ramREN, 1'b1);
      chk("midrst_ramaddr_before", ramaddr, 32'h100);
      nRST = 1'b0;
      #1;
      chk("midrst_ramREN_async", ramREN, 1'b0);
      chk("midrst_ramaddr_async", ramaddr, 32'h0);
      iREN = 1'b0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      i0 = ihit_cnt;
      repeat (6) @(negedge CLK);
      chk("midrst_no_ihit", ihit_cnt, i0);
      chk("midrst_no_op", ops.size(), 0);
      $display("txn reset-mid-access done");

      // Instruction read with 3 wait cycles
      run_pair(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 3);
      // Simultaneous data write and instruction fetch
      run_pair(2, 1'b1, 1'b1, 32'h200, 32'h12345678, 1'b1, 32'h10, 1);

      // Request inputs change during a data access
      rdy_delay = 2;
      e0 = ref_mem[8'h80];
      @(posedge CLK); #1;
      start = cyc;
      dREN = 1'b1; daddr = 32'h200;
      @(posedge CLK); #1;
      daddr = 32'h300; dREN = 1'b0;
      @(negedge CLK);
      chk("chg_ramaddr", ramaddr, 32'h200);
      wait_hit(1'b1, 20, at0, ok);
      chk("chg_dhit", ok, 1'b1);
      chk("chg_latency", at0 - start, 4);
      chk("chg_dload", dload, e0);
      check_op("chg_op", 1'b0, 32'h200, '0);
      $display("txn input-change done at=%0d", at0 - start);

      // Back-to-back data reads with ram_rdy on the first access cycle
      rdy_delay = 0;
      e0 = ref_mem[0];
      e1 = ref_mem[1];
      @(posedge CLK); #1;
      dREN = 1'b1; daddr = 32'h0;
      wait_hit(1'b1, 20, at0, ok);
      chk("b2b_hit0", ok, 1'b1);
      chk("b2b_dload0", dload, e0);
      @(posedge CLK); #1;
      daddr = 32'h4;
      wait_hit(1'b1, 20, at1, ok);
      chk("b2b_hit1", ok, 1'b1);
      chk("b2b_dload1", dload, e1);
      chk("b2b_spacing", at1 - at0, 3);
      @(posedge CLK); #1;
      dREN = 1'b0;
      check_op("b2b_op0", 1'b0, 32'h0, '0);
      check_op("b2b_op1", 1'b0, 32'h4, '0);
      $display("txn back-to-back done spacing=%0d", at1 - at0);

      // Random traffic with spurious ram_rdy outside accesses
      noise_en = 1'b1;
      for (int t = 0; t < 30; t++) begin
         bit            ud, ui, wr;
         int            kind;
         logic [AW-1:0] da, ia;
         kind = $urandom_range(0, 2);
         ud = (kind != 1);
         ui = (kind != 0);
         wr = 1'($urandom_range(0, 1));
         da = {22'h0, 4'($urandom_range(0, 15)), 6'h0} | {28'h0, 2'($urandom_range(0, 3)), 2'b00};
         ia = ($urandom_range(0, 2) == 0) ? da : {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         run_pair(10 + t, ud, wr, da, $urandom, ui, ia, $urandom_range(0, 4));
      end
      noise_en = 1'b0;

`ifdef MEM_ARB_WDOG_EN
      // Watchdog: ram_rdy never arrives
      rdy_delay = -1;
      @(posedge CLK); #1;
      start = cyc;
      iREN = 1'b1; iaddr = 32'h80;
      wait_hit(1'b0, 40, at0, ok);
      chk("wdog_ihit", ok, 1'b1);
      chk("wdog_latency", at0 - start, WD + 1);
      chk("wdog_iload", iload, 32'h0);
      chk("wdog_mem_err", mem_err, 1'b1);
      @(posedge CLK); #1;
      iREN = 1'b0;
      repeat (5) @(negedge CLK);
      chk("wdog_sticky", mem_err, 1'b1);
      nRST = 1'b0;
      #1;
      chk("wdog_reset_clear", mem_err, 1'b0);
      @(negedge CLK);
      nRST = 1'b1;
      $display("txn watchdog done at=%0d", at0 - start);
`else
      chk("no_wdog_mem_err", mem_err, 1'b0);
`endif

      repeat (2) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the fetch-stage instruction port and the MEM-stage data port onto the single-ported RAM.
- Produces the ihit/dhit strobes and load data that the hazard unit and pipeline latches consume.
- Sits between the datapath/caches and RAM, directly upstream of the hazard unit.
- Data requests have fixed priority over instruction requests, because the data request belongs to the older instruction.

Parameters:
ADDR_W, 32, address width for both ports and RAM
DATA_W, 32, data width for both ports and RAM
WDOG_CYCLES, 255, cycles an access may wait for ram_rdy before mem_err is raised (only with MEM_ARB_WDOG_EN)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request (level, held until ihit)
iaddr  in  ADDR_W  instruction address
iload  out  DATA_W  instruction read data, valid while ihit=1
ihit  out  1  one-cycle instruction completion strobe
dREN  in  1  data read request (level, held until dhit)
dWEN  in  1  data write request (level, held until dhit)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
dload  out  DATA_W  data read data, valid while dhit=1
dhit  out  1  one-cycle data completion strobe
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid when ram_rdy=1
ram_rdy  in  1  RAM access complete this cycle
mem_err  out  1  sticky watchdog error (tied 0 without MEM_ARB_WDOG_EN)

Behaviour:
- Single clock domain; all state registered on CLK rising edge.
- nRST=0 asynchronously forces:
  - state=IDLE
  - ihit=dhit=0, iload=dload=0
  - ramREN=ramWEN=0, ramaddr=ramstore=0
  - mem_err=0
  - watchdog counter=0
- States: IDLE, DACC, IACC, RESP.
- IDLE:
  - If dREN|dWEN: latch daddr, dstore and op (write if dWEN, else read), then go to DACC.
  - Else if iREN: latch iaddr, then go to IACC.
  - Else stay in IDLE.
  - Data always wins a simultaneous request.
- DACC/IACC:
  - ramaddr/ramstore are driven from the latched copies.
  - Exactly one of ramREN/ramWEN is asserted.
  - IACC is always a read.
  - Changes on the request inputs during the access are ignored. The access cannot be aborted and always runs to completion.
- ram_rdy=1 while in DACC/IACC:
  - Register ramload into dload/iload (read only; writes leave dload unchanged).
  - Go to RESP with a record of which port was served.
  - ramREN/ramWEN drop to 0 in RESP.
- ram_rdy while in IDLE or RESP is ignored.
- RESP:
  - Assert exactly one of dhit/ihit for this single cycle.
  - No arbitration occurs, so the requester can advance its request at the edge.
  - Next state is IDLE, unconditionally.
- Minimum latency: request seen at IDLE cycle 0, ram_rdy in cycle 1, hit in cycle 2.
- Turnaround: one IDLE cycle between back-to-back accesses.
- Hit strobes pulse even if the requester dropped its request mid-access; the consumer ignores unexpected hits.
- ihit and dhit are never high together.
- dREN and dWEN both high: treated as a write.
- Starvation: continuous data requests starve fetch by design, because the pipeline stalls on dhit.
- Reset mid-access: the access is abandoned, no hit is produced, and the RAM enables drop asynchronously.

Optional Feature:
- Macro MEM_ARB_WDOG_EN.
- Defined:
  - A counter clears on entry to DACC/IACC and increments each cycle ram_rdy=0 in those states.
  - When it reaches WDOG_CYCLES: set mem_err (sticky until nRST), force RESP with the hit for the pending port, and load data=0.
  - Counter width = clog2(WDOG_CYCLES+1).
- Undefined: no counter exists, mem_err is tied 0, and an access waits for ram_rdy indefinitely.

Test Plan:
- Reset mid-access: drive iREN=1, iaddr=0x100, assert nRST=0 during IACC → ramREN=0 immediately; after release no ihit occurs until a new request.
- Instruction read: iREN=1, iaddr=0x40, RAM returns 0xDEADBEEF with 3-cycle ram_rdy delay → ramaddr=0x40 in IACC; ihit=1 for exactly one cycle with iload=0xDEADBEEF; dhit stays 0.
- Simultaneous request: iREN=1 (0x10) and dWEN=1 (daddr=0x200, dstore=0x12345678) in the same cycle → RAM write to 0x200 first, then dhit; fetch of 0x10 starts after RESP+IDLE; ihit follows.
- Input change mid-access: during DACC change daddr to 0x300 and drop dREN → RAM still sees 0x200; dhit still pulses.
- Back-to-back reads, ram_rdy in the first cycle: data reads 0x0/0x4 → hits 3 cycles apart; no cycle has both hits.
- With MEM_ARB_WDOG_EN, WDOG_CYCLES=8, ram_rdy held 0: iREN=1 → ihit after 8 wait cycles, iload=0, mem_err=1 and stays 1 until nRST.
